// File: rtl/mod_chinh_ctrl_if.sv
// Front-panel adjust controller bundle: raw buttons and 1 Hz tick in, adjust mode and step pulses out.
// Grouped so the display top level can route the whole panel as one port.
interface mod_chinh_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_dn;
    logic       tick_1hz;
    logic [1:0] gt_mod;
    logic       adj_up;
    logic       adj_dn;
    logic       blink;

    modport master (
        output btn_mode, btn_up, btn_dn, tick_1hz,
        input  gt_mod, adj_up, adj_dn, blink
    );

    modport slave (
        input  btn_mode, btn_up, btn_dn, tick_1hz,
        output gt_mod, adj_up, adj_dn, blink
    );
endinterface

// File: rtl/mod_chinh_ctrl.sv
// Debounced MODE/UP/DOWN front-panel controller: adjust-mode sequencing, auto-repeat steps, idle timeout, blink.
// Latency: outputs registered, one cycle after the debounced press or tick; no backpressure, pulses are fire-and-forget.
module mod_chinh_ctrl #(
    parameter int DEB_CYC   = 500000,
    parameter int HOLD_CYC  = 25000000,
    parameter int REP_CYC   = 5000000,
    parameter int TIMEOUT_S = 10,
    parameter int BLINK_CYC = 12500000
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_chinh_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYC) + 1;
    localparam int HW = $clog2(HOLD_CYC) + 1;
    localparam int RW = $clog2(REP_CYC) + 1;
    localparam int IW = $clog2(TIMEOUT_S) + 1;
    localparam int BW = $clog2(BLINK_CYC) + 1;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_SEC  = 2'b01,
        MODE_MIN  = 2'b10,
        MODE_HR   = 2'b11
    } mode_e;

    // bit 0 = MODE, bit 1 = UP, bit 2 = DOWN
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    mode_e         mode;
    logic          adj_up_q;
    logic          adj_dn_q;
    logic          blink_q;

    mode_e         mode_nxt;
    logic          up_only;
    logic          dn_only;
    logic          held;
    logic          rep_fire;
    logic          step_up;
    logic          step_dn;
    logic          activity;
    logic          timeout;
    logic          blink_ph_nxt;

    assign btn_raw    = {bus.btn_dn, bus.btn_up, bus.btn_mode};
    assign press      = stable & ~stable_d;
    assign bus.gt_mod = mode;
    assign bus.adj_up = adj_up_q;
    assign bus.adj_dn = adj_dn_q;
    assign bus.blink  = blink_q;

    always_comb begin
        up_only  = stable[1] & ~stable[2];
        dn_only  = stable[2] & ~stable[1];
        // A repeat hold only runs with exactly one of UP/DOWN down, in an adjust mode, and no MODE press.
        held     = (up_only | dn_only) && (mode != MODE_NONE) && !press[0];
        rep_fire = held && !(press[1] || press[2]) && (hold_cnt == HW'(HOLD_CYC))
                   && ((rep_cnt == '0) || (rep_cnt == RW'(REP_CYC)));
        step_up  = held && up_only && (press[1] || rep_fire);
        step_dn  = held && dn_only && (press[2] || rep_fire);
        activity = (|press) || rep_fire;
        timeout  = (mode != MODE_NONE) && bus.tick_1hz && !activity
                   && (idle_cnt == IW'(TIMEOUT_S - 1));

        mode_nxt = mode;
        if (press[0]) begin
            mode_nxt = mode_e'(mode + 2'd1);
        end else if (timeout) begin
            mode_nxt = MODE_NONE;
        end

        blink_ph_nxt = blink_ph;
        if (press[0]) begin
            blink_ph_nxt = 1'b1;
        end else if ((mode != MODE_NONE) && (blink_cnt == BW'(BLINK_CYC - 1))) begin
            blink_ph_nxt = ~blink_ph;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            stable_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            mode      <= MODE_NONE;
            adj_up_q  <= 1'b0;
            adj_dn_q  <= 1'b0;
            blink_q   <= 1'b1;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end

            // hold_cnt parks at HOLD_CYC; rep_cnt then paces the repeats and never exceeds REP_CYC.
            if (!held) begin
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else if (press[1] || press[2]) begin
                hold_cnt <= HW'(1);
                rep_cnt  <= '0;
            end else if (hold_cnt != HW'(HOLD_CYC)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (rep_fire) begin
                rep_cnt  <= RW'(1);
            end else begin
                rep_cnt  <= rep_cnt + 1'b1;
            end

            if (press[0] || timeout || (mode == MODE_NONE) || activity) begin
                idle_cnt <= '0;
            end else if (bus.tick_1hz && (idle_cnt != IW'(TIMEOUT_S))) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (press[0] || (blink_cnt == BW'(BLINK_CYC - 1))) begin
                blink_cnt <= '0;
            end else if (mode != MODE_NONE) begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            mode     <= mode_nxt;
            blink_ph <= blink_ph_nxt;
            adj_up_q <= step_up;
            adj_dn_q <= step_dn;
            blink_q  <= (mode_nxt == MODE_NONE) || held || blink_ph_nxt;
        end
    end
endmodule

// File: tb/tb_mod_chinh_ctrl.sv
// Directed panel scenarios followed by random button/tick traffic, checked every cycle against a timestamp-based model.
module tb_mod_chinh_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int TMO  = 3;
    localparam int BLK  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_mode = 1'b0, r_up = 1'b0, r_dn = 1'b0, r_tick = 1'b0;

    mod_chinh_ctrl_if bus ();

    mod_chinh_ctrl #(
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .REP_CYC  (REP),
        .TIMEOUT_S(TMO),
        .BLINK_CYC(BLK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_up = 0;
    int n_dn = 0;
    int dn_q[$];

    // Reference model state: raw-level histories, stable levels, timestamps.
    logic [DEB+1:0] h_m, h_u, h_d;
    logic [2:0] m_st, m_stp;
    int  cyc = 0;
    int  m_mode = 0, m_idle = 0, m_hs = 0, m_entry = 0;
    bit  m_active = 0;
    int  e_mode = 0;
    bit  e_up = 0, e_dn = 0, e_blink = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // A level is accepted once the last DEB synchronized samples (raw two edges back) all differ from it.
    function automatic bit accepts(input logic [DEB+1:0] h, input logic st);
        for (int i = 2; i <= DEB + 1; i++) begin
            if (h[i] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit pm, pu, pd, up_only, dn_only, held, fire, stepp;
        int age;
        cyc++;
        if (!rst_n) begin
            h_m = '0; h_u = '0; h_d = '0;
            m_st = '0; m_stp = '0;
            m_mode = 0; m_idle = 0; m_active = 0;
            e_mode = 0; e_up = 0; e_dn = 0; e_blink = 1;
            return;
        end
        pm = m_st[0] & ~m_stp[0];
        pu = m_st[1] & ~m_stp[1];
        pd = m_st[2] & ~m_stp[2];
        up_only = m_st[1] & ~m_st[2];
        dn_only = m_st[2] & ~m_st[1];
        held = (up_only || dn_only) && (m_mode != 0) && !pm;
        fire = 0;
        stepp = 0;
        if (!held) begin
            m_active = 0;
        end else if (pu || pd || !m_active) begin
            m_active = 1;
            m_hs = cyc;
            stepp = pu || pd;
        end else begin
            age = cyc - m_hs;
            fire = (age == HOLD) || (age > HOLD && ((age - HOLD) % REP) == 0);
            stepp = fire;
        end
        e_up = stepp && up_only;
        e_dn = stepp && dn_only;
        if (pm) begin
            m_mode = (m_mode + 1) % 4;
            m_idle = 0;
            m_entry = cyc;
        end else if (m_mode != 0) begin
            if (pu || pd || fire) begin
                m_idle = 0;
            end else if (r_tick) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_mode = 0;
                    m_idle = 0;
                end
            end
        end
        e_mode = m_mode;
        e_blink = (m_mode == 0) || held || ((((cyc - m_entry) / BLK) % 2) == 0);
        m_stp = m_st;
        h_m = {h_m[DEB:0], r_mode};
        h_u = {h_u[DEB:0], r_up};
        h_d = {h_d[DEB:0], r_dn};
        if (accepts(h_m, m_st[0])) m_st[0] = ~m_st[0];
        if (accepts(h_u, m_st[1])) m_st[1] = ~m_st[1];
        if (accepts(h_d, m_st[2])) m_st[2] = ~m_st[2];
    endtask

    // One clock: drive inputs at the falling edge, sample and compare 1 time unit after the rising edge.
    task automatic step();
        bus.btn_mode = r_mode;
        bus.btn_up   = r_up;
        bus.btn_dn   = r_dn;
        bus.tick_1hz = r_tick;
        @(posedge clk);
        model_edge();
        #1;
        chk("gt_mod", bus.gt_mod, e_mode);
        chk("adj_up", bus.adj_up, e_up);
        chk("adj_dn", bus.adj_dn, e_dn);
        chk("blink", bus.blink, e_blink);
        chk("adj_excl", bus.adj_up & bus.adj_dn, 0);
        if (bus.adj_up === 1'b1) n_up++;
        if (bus.adj_dn === 1'b1) begin
            n_dn++;
            dn_q.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_mode();
        r_mode = 1'b1;
        steps(10);
        r_mode = 1'b0;
        steps(10);
    endtask

    initial begin
        int start_cyc;
        int len;
        h_m = '0; h_u = '0; h_d = '0;
        m_st = '0; m_stp = '0;

        // Reset state
        rst_n = 1'b0;
        steps(3);
        chk("rst_gt_mod", bus.gt_mod, 0);
        chk("rst_adj_up", bus.adj_up, 0);
        chk("rst_blink", bus.blink, 1);
        rst_n = 1'b1;

        // MODE sequencing 01,10,11,00, each step 7 cycles after the raw rise
        for (int p = 0; p < 4; p++) begin
            r_mode = 1'b1;
            for (int j = 1; j <= 10; j++) begin
                step();
                if (j == 6) chk("mode_before", bus.gt_mod, p);
                if (j == 7) chk("mode_after", bus.gt_mod, (p + 1) % 4);
            end
            r_mode = 1'b0;
            steps(10);
        end

        // 2-cycle glitch on UP in mode 01
        press_mode();
        n_up = 0;
        r_up = 1'b1;
        steps(2);
        r_up = 1'b0;
        steps(15);
        chk("glitch_no_pulse", n_up, 0);
        chk("glitch_mode", bus.gt_mod, 1);

        // DOWN held in mode 10: pulses at press, press+20, press+28
        press_mode();
        n_up = 0;
        n_dn = 0;
        dn_q.delete();
        start_cyc = cyc;
        r_dn = 1'b1;
        steps(45);
        r_dn = 1'b0;
        steps(12);
        chk("rep_count_min3", (dn_q.size() >= 3), 1);
        if (dn_q.size() >= 3) begin
            chk("rep_first", dn_q[0] - start_cyc, 7);
            chk("rep_hold", dn_q[1] - dn_q[0], HOLD);
            chk("rep_period", dn_q[2] - dn_q[0], HOLD + REP);
        end
        chk("rep_no_up", n_up, 0);

        // Idle timeout in mode 11
        press_mode();
        chk("mode_11", bus.gt_mod, 3);
        for (int t = 1; t <= 3; t++) begin
            r_tick = 1'b1;
            step();
            r_tick = 1'b0;
            if (t < 3) chk("tmo_hold", bus.gt_mod, 3);
            else begin
                chk("tmo_mode", bus.gt_mod, 0);
                chk("tmo_blink", bus.blink, 1);
            end
            steps(4);
        end

        // MODE+UP together, then UP+DOWN together
        press_mode();
        n_up = 0;
        n_dn = 0;
        r_mode = 1'b1;
        r_up = 1'b1;
        steps(10);
        chk("mode_up_mode", bus.gt_mod, 2);
        r_mode = 1'b0;
        r_up = 1'b0;
        steps(10);
        chk("mode_up_no_pulse", n_up, 0);
        r_up = 1'b1;
        r_dn = 1'b1;
        steps(40);
        r_up = 1'b0;
        r_dn = 1'b0;
        steps(10);
        chk("both_no_up", n_up, 0);
        chk("both_no_dn", n_dn, 0);

        // Reset during an UP repeat in mode 01
        press_mode();
        press_mode();
        press_mode();
        chk("mode_01", bus.gt_mod, 1);
        n_up = 0;
        r_up = 1'b1;
        steps(30);
        chk("repeat_before_rst", n_up, 2);
        rst_n = 1'b0;
        step();
        chk("midrst_mode", bus.gt_mod, 0);
        chk("midrst_up", bus.adj_up, 0);
        chk("midrst_blink", bus.blink, 1);
        rst_n = 1'b1;
        n_up = 0;
        steps(30);
        chk("post_rst_no_up", n_up, 0);
        chk("post_rst_mode", bus.gt_mod, 0);
        r_up = 1'b0;
        steps(10);

        // Random traffic against the model
        for (int s = 0; s < 150; s++) begin
            r_mode = ($urandom_range(0, 5) == 0);
            r_up = ($urandom_range(0, 2) == 0);
            r_dn = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                r_tick = ($urandom_range(0, 15) == 0);
                rst_n = !($urandom_range(0, 499) == 0);
                step();
            end
        end
        rst_n = 1'b1;
        r_mode = 1'b0;
        r_up = 1'b0;
        r_dn = 1'b0;
        r_tick = 1'b0;
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
